// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RV32I pipeline.
// Issues one word-aligned data-cache request per load/store, formats store
// data and byte enables, aligns and extends load data, and presents a
// registered result to the MEM/WB register. Upstream is stalled until the
// cache answers.
module mem_stage #(
  parameter int WB_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [2:0]      load_funct3_i,
  input  logic [2:0]      store_funct3_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     rs2_i,
  input  logic [WB_W-1:0] wb_i,
  input  logic            dmem_resp,
  input  logic [31:0]     dmem_rdata,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [31:0]     dmem_address,
  output logic [31:0]     dmem_wdata,
  output logic [3:0]      dmem_mbe,
  output logic            stall_o,
  output logic            valid_o,
  output logic [31:0]     rdata_o,
  output logic [31:0]     addr_o,
  output logic [WB_W-1:0] wb_o,
  output logic            misaligned_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic            dmemRead_q, dmemRead_d;
  logic            dmemWrite_q, dmemWrite_d;
  logic [31:0]     dmemAddr_q, dmemAddr_d;
  logic [31:0]     dmemWdata_q, dmemWdata_d;
  logic [3:0]      dmemMbe_q, dmemMbe_d;
  logic            valid_q, valid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     addrOut_q, addrOut_d;
  logic [WB_W-1:0] wbOut_q, wbOut_d;
  logic            misaligned_q, misaligned_d;
  logic [2:0]      ldFunct3_q, ldFunct3_d;
  logic [1:0]      ldOffset_q, ldOffset_d;

  logic        memOp;
  logic        badAccess;
  logic        loadLegal;
  logic        loadMisaligned;
  logic        storeLegal;
  logic        storeMisaligned;
  logic [31:0] storeData;
  logic [3:0]  storeMbe;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;

  // Classify the incoming instruction: real memory access, or one to be flagged.
  always_comb begin
    memOp           = valid_i & (mem_read_i ^ mem_write_i);
    loadLegal       = load_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    storeLegal      = store_funct3_i inside {3'b000, 3'b001, 3'b010};
    loadMisaligned  = ((load_funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) ||
                      ((load_funct3_i[1:0] == 2'b01) && addr_i[0]);
    storeMisaligned = ((store_funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) ||
                      ((store_funct3_i[1:0] == 2'b01) && addr_i[0]);
    badAccess       = valid_i & ((mem_read_i & mem_write_i) |
                                 (mem_read_i & (~loadLegal | loadMisaligned)) |
                                 (mem_write_i & (~storeLegal | storeMisaligned)));
  end

  // Replicate store data across the word and pick the byte lanes to write.
  always_comb begin
    storeData = 32'h0000_0000;
    storeMbe  = 4'b0000;
    case (store_funct3_i)
      3'b000: begin
        storeData = {4{rs2_i[7:0]}};
        storeMbe  = 4'b0001 << addr_i[1:0];
      end
      3'b001: begin
        storeData = {2{rs2_i[15:0]}};
        storeMbe  = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        storeData = rs2_i;
        storeMbe  = 4'b1111;
      end
      default: begin
        storeData = 32'h0000_0000;
        storeMbe  = 4'b0000;
      end
    endcase
  end

  // Pull the addressed byte/half out of the returned word and extend it.
  always_comb begin
    loadByte = 8'h00;
    loadData = 32'h0000_0000;
    case (ldOffset_q)
      2'd0:    loadByte = dmem_rdata[7:0];
      2'd1:    loadByte = dmem_rdata[15:8];
      2'd2:    loadByte = dmem_rdata[23:16];
      default: loadByte = dmem_rdata[31:24];
    endcase
    loadHalf = ldOffset_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ldFunct3_q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b010:  loadData = dmem_rdata;
      3'b100:  loadData = {24'h00_0000, loadByte};
      3'b101:  loadData = {16'h0000, loadHalf};
      default: loadData = 32'h0000_0000;
    endcase
  end

  // Next-state and stall logic for the IDLE -> REQ -> DONE access sequence.
  always_comb begin
    state_d      = state_q;
    dmemRead_d   = dmemRead_q;
    dmemWrite_d  = dmemWrite_q;
    dmemAddr_d   = dmemAddr_q;
    dmemWdata_d  = dmemWdata_q;
    dmemMbe_d    = dmemMbe_q;
    valid_d      = 1'b0;
    rdata_d      = rdata_q;
    addrOut_d    = addrOut_q;
    wbOut_d      = wbOut_q;
    misaligned_d = misaligned_q;
    ldFunct3_d   = ldFunct3_q;
    ldOffset_d   = ldOffset_q;
    stall_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          addrOut_d = addr_i;
          wbOut_d   = wb_i;
          if (memOp && !badAccess) begin
            stall_o     = 1'b1;
            state_d     = REQ;
            dmemRead_d  = mem_read_i;
            dmemWrite_d = mem_write_i;
            dmemAddr_d  = {addr_i[31:2], 2'b00};
            dmemWdata_d = mem_write_i ? storeData : 32'h0000_0000;
            dmemMbe_d   = mem_write_i ? storeMbe : 4'b1111;
            ldFunct3_d  = load_funct3_i;
            ldOffset_d  = addr_i[1:0];
          end else begin
            valid_d      = 1'b1;
            rdata_d      = 32'h0000_0000;
            misaligned_d = badAccess;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem_resp) begin
          dmemRead_d   = 1'b0;
          dmemWrite_d  = 1'b0;
          valid_d      = 1'b1;
          rdata_d      = dmemRead_q ? loadData : 32'h0000_0000;
          misaligned_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight request at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      dmemRead_q   <= 1'b0;
      dmemWrite_q  <= 1'b0;
      dmemAddr_q   <= 32'h0000_0000;
      dmemWdata_q  <= 32'h0000_0000;
      dmemMbe_q    <= 4'b0000;
      valid_q      <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      addrOut_q    <= 32'h0000_0000;
      wbOut_q      <= '0;
      misaligned_q <= 1'b0;
      ldFunct3_q   <= 3'b000;
      ldOffset_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      dmemRead_q   <= dmemRead_d;
      dmemWrite_q  <= dmemWrite_d;
      dmemAddr_q   <= dmemAddr_d;
      dmemWdata_q  <= dmemWdata_d;
      dmemMbe_q    <= dmemMbe_d;
      valid_q      <= valid_d;
      rdata_q      <= rdata_d;
      addrOut_q    <= addrOut_d;
      wbOut_q      <= wbOut_d;
      misaligned_q <= misaligned_d;
      ldFunct3_q   <= ldFunct3_d;
      ldOffset_q   <= ldOffset_d;
    end
  end

  assign dmem_read    = dmemRead_q;
  assign dmem_write   = dmemWrite_q;
  assign dmem_address = dmemAddr_q;
  assign dmem_wdata   = dmemWdata_q;
  assign dmem_mbe     = dmemMbe_q;
  assign valid_o      = valid_q;
  assign rdata_o      = rdata_q;
  assign addr_o       = addrOut_q;
  assign wb_o         = wbOut_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// byte-level behavioural model of RV32I load/store semantics.
module tb_mem_stage;

  localparam int WB_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            valid_i = 1'b0;
  logic            mem_read_i = 1'b0;
  logic            mem_write_i = 1'b0;
  logic [2:0]      load_funct3_i = 3'd0;
  logic [2:0]      store_funct3_i = 3'd0;
  logic [31:0]     addr_i = 32'd0;
  logic [31:0]     rs2_i = 32'd0;
  logic [WB_W-1:0] wb_i = '0;
  logic            dmem_resp = 1'b0;
  logic [31:0]     dmem_rdata = 32'd0;
  logic            dmem_read;
  logic            dmem_write;
  logic [31:0]     dmem_address;
  logic [31:0]     dmem_wdata;
  logic [3:0]      dmem_mbe;
  logic            stall_o;
  logic            valid_o;
  logic [31:0]     rdata_o;
  logic [31:0]     addr_o;
  logic [WB_W-1:0] wb_o;
  logic            misaligned_o;

  int checks = 0;
  int errors = 0;

  mem_stage #(.WB_W(WB_W)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .load_funct3_i(load_funct3_i),
    .store_funct3_i(store_funct3_i), .addr_i(addr_i), .rs2_i(rs2_i),
    .wb_i(wb_i), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_mbe(dmem_mbe), .stall_o(stall_o), .valid_o(valid_o),
    .rdata_o(rdata_o), .addr_o(addr_o), .wb_o(wb_o),
    .misaligned_o(misaligned_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        isMem;
    logic        bad;
    logic        isLoad;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  mbe;
  } exp_t;

  // Reference behaviour: access size from funct3, alignment by modulo,
  // load extraction by shifting the word, store replication by multiplication.
  function automatic exp_t modelAccess(input logic rd, input logic wr,
                                       input logic [2:0] lf, input logic [2:0] sf,
                                       input logic [31:0] a, input logic [31:0] d,
                                       input logic [31:0] word);
    exp_t m;
    int size;
    int off;
    logic legal;
    longint unsigned mask;
    longint unsigned val;
    longint unsigned w64;
    longint unsigned d64;
    longint unsigned mult;
    m = '0;
    size = 1;
    if (rd && wr) begin
      m.bad = 1'b1;
      return m;
    end
    if (!rd && !wr) return m;
    if (rd) begin
      legal = (lf == 3'd0) || (lf == 3'd1) || (lf == 3'd2) || (lf == 3'd4) || (lf == 3'd5);
      size  = 1 << int'(lf[1:0]);
    end else begin
      legal = (sf <= 3'd2);
      size  = 1 << int'(sf[1:0]);
    end
    off = int'(a % 32'd4);
    if (!legal || (off % size) != 0) begin
      m.bad = 1'b1;
      return m;
    end
    m.isMem  = 1'b1;
    m.isLoad = rd;
    m.addr   = a - (a % 32'd4);
    mask     = (64'd1 << (8 * size)) - 64'd1;
    if (rd) begin
      m.mbe   = 4'hF;
      m.wdata = 32'd0;
      w64     = 64'(word);
      val     = (w64 >> (8 * off)) & mask;
      if (lf < 3'd4 && size < 4 && val[8 * size - 1]) val = val | ~mask;
      m.rdata = val[31:0];
    end else begin
      m.mbe   = 4'(((1 << size) - 1) << off);
      d64     = 64'(d);
      mult    = (size == 1) ? 64'h0101_0101 : (size == 2) ? 64'h0001_0001 : 64'h1;
      val     = (d64 & mask) * mult;
      m.wdata = val[31:0];
      m.rdata = 32'd0;
    end
    return m;
  endfunction

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one instruction in EX/MEM and follow it until it leaves the stage.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] lf,
                               input logic [2:0] sf, input logic [31:0] a,
                               input logic [31:0] d, input logic [7:0] wb,
                               input int lat, input logic [31:0] word,
                               input logic spurious);
    exp_t m;
    int stallCycles;
    m = modelAccess(rd, wr, lf, sf, a, d, word);
    valid_i = 1'b1;
    mem_read_i = rd;
    mem_write_i = wr;
    load_funct3_i = lf;
    store_funct3_i = sf;
    addr_i = a;
    rs2_i = d;
    wb_i = wb;
    dmem_resp = spurious;
    dmem_rdata = $urandom;
    #1;
    if (!m.isMem) begin
      checkOutput("nomem_stall", 32'(stall_o), 32'd0);
      @(posedge clk);
      #1;
      dmem_resp = 1'b0;
      checkOutput("nomem_valid", 32'(valid_o), 32'd1);
      checkOutput("nomem_misaligned", 32'(misaligned_o), 32'(m.bad));
      checkOutput("nomem_rdata", rdata_o, 32'd0);
      checkOutput("nomem_addr_o", addr_o, a);
      checkOutput("nomem_wb_o", 32'(wb_o), 32'(wb));
      checkOutput("nomem_no_read", 32'(dmem_read), 32'd0);
      checkOutput("nomem_no_write", 32'(dmem_write), 32'd0);
    end else begin
      stallCycles = 0;
      if (stall_o) stallCycles++;
      @(posedge clk);
      #1;
      checkOutput("req_read", 32'(dmem_read), 32'(rd));
      checkOutput("req_write", 32'(dmem_write), 32'(wr));
      checkOutput("req_address", dmem_address, m.addr);
      checkOutput("req_wdata", dmem_wdata, m.wdata);
      checkOutput("req_mbe", 32'(dmem_mbe), 32'(m.mbe));
      checkOutput("req_valid_low", 32'(valid_o), 32'd0);
      for (int i = 0; i <= lat; i++) begin
        if (i == lat) begin
          dmem_resp = 1'b1;
          dmem_rdata = word;
        end
        #1;
        if (stall_o) stallCycles++;
        checkOutput("req_read_held", 32'(dmem_read), 32'(rd));
        checkOutput("req_write_held", 32'(dmem_write), 32'(wr));
        checkOutput("req_address_held", dmem_address, m.addr);
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        dmem_rdata = $urandom;
      end
      checkOutput("done_valid", 32'(valid_o), 32'd1);
      checkOutput("done_rdata", rdata_o, m.isLoad ? m.rdata : 32'd0);
      checkOutput("done_misaligned", 32'(misaligned_o), 32'd0);
      checkOutput("done_stall", 32'(stall_o), 32'd0);
      checkOutput("done_read_drop", 32'(dmem_read), 32'd0);
      checkOutput("done_write_drop", 32'(dmem_write), 32'd0);
      checkOutput("done_addr_o", addr_o, a);
      checkOutput("done_wb_o", 32'(wb_o), 32'(wb));
      checkOutput("stall_cycles", 32'(stallCycles), 32'(lat + 2));
      @(posedge clk);
      #1;
      checkOutput("after_done_valid", 32'(valid_o), 32'd0);
    end
  endtask

  // Idle cycle with no live instruction, optionally with a stray cache response.
  task automatic applyBubble(input logic spurious);
    valid_i = 1'b0;
    mem_read_i = 1'($urandom_range(0, 1));
    mem_write_i = 1'b0;
    dmem_resp = spurious;
    @(posedge clk);
    #1;
    dmem_resp = 1'b0;
    checkOutput("bubble_valid", 32'(valid_o), 32'd0);
    checkOutput("bubble_no_read", 32'(dmem_read), 32'd0);
    checkOutput("bubble_no_write", 32'(dmem_write), 32'd0);
  endtask

  initial begin
    int kind;
    logic [31:0] ra;
    logic [2:0] rf;

    // Reset state
    #1;
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_read", 32'(dmem_read), 32'd0);
    checkOutput("reset_write", 32'(dmem_write), 32'd0);
    checkOutput("reset_address", dmem_address, 32'd0);
    checkOutput("reset_mbe", 32'(dmem_mbe), 32'd0);
    checkOutput("reset_rdata", rdata_o, 32'd0);
    checkOutput("reset_misaligned", 32'(misaligned_o), 32'd0);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed cases
    applyStimulus(1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_0100, 32'h0, 8'h11, 2, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 3'b000, 32'h0000_0103, 32'h0, 8'h12, 0, 32'h80FF_1234, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b100, 3'b000, 32'h0000_0103, 32'h0, 8'h13, 1, 32'h80FF_1234, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b101, 3'b000, 32'h0000_0102, 32'h0, 8'h14, 3, 32'h80FF_1234, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b000, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 8'h15, 1, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_0301, 32'h0000_00C3, 8'h16, 0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_0101, 32'h0, 8'h17, 0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 32'h0000_0044, 32'h0, 8'h5A, 0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'b010, 3'b010, 32'h0000_0400, 32'h0, 8'h18, 0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b011, 3'b000, 32'h0000_0400, 32'h0, 8'h19, 0, 32'h0, 1'b0);
    applyBubble(1'b1);

    // Reset while a request is outstanding, then the held load reissues
    valid_i = 1'b1;
    mem_read_i = 1'b1;
    mem_write_i = 1'b0;
    load_funct3_i = 3'b010;
    addr_i = 32'h0000_0300;
    wb_i = 8'h21;
    @(posedge clk);
    #1;
    checkOutput("rst_pre_read", 32'(dmem_read), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_read_drop", 32'(dmem_read), 32'd0);
    checkOutput("rst_address_clear", dmem_address, 32'd0);
    checkOutput("rst_mbe_clear", 32'(dmem_mbe), 32'd0);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_0300, 32'h0, 8'h21, 1, 32'h1357_9BDF, 1'b0);

    // Randomized mix of operations
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 4));
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      rf = 3'($urandom_range(0, 7));
      case (kind)
        0: applyStimulus(1'b0, 1'b0, rf, rf, ra, $urandom, 8'($urandom), 0, 32'h0,
                         1'($urandom_range(0, 1)));
        1: applyStimulus(1'b1, 1'b0, rf, 3'b000, ra, $urandom, 8'($urandom),
                         int'($urandom_range(0, 3)), $urandom, 1'b0);
        2: applyStimulus(1'b0, 1'b1, 3'b000, 3'($urandom_range(0, 3)), ra, $urandom,
                         8'($urandom), int'($urandom_range(0, 3)), $urandom, 1'b0);
        3: applyStimulus(1'b1, 1'b1, rf, rf, ra, $urandom, 8'($urandom), 0, 32'h0, 1'b0);
        default: applyBubble(1'($urandom_range(0, 1)));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
